// File: rtl/snitch_icache_tag_ctrl.sv
// rtl/snitch_icache_tag_ctrl.sv - tag SRAM initiator: init/flush sweep, refill tag writes, lookups
// Tag word layout is {valid, error, tag}; read words arrive one cycle after a read request.
module snitch_icache_tag_ctrl #(
  parameter int WAY_COUNT   = 4,
  parameter int LINE_COUNT  = 128,
  parameter int TAG_WIDTH   = 20,
  parameter int COUNT_ALIGN = $clog2(LINE_COUNT)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_valid_i,
  output logic                               flush_ready_o,
  input  logic                               lookup_valid_i,
  output logic                               lookup_ready_o,
  input  logic [COUNT_ALIGN-1:0]             lookup_addr_i,
  input  logic [TAG_WIDTH-1:0]               lookup_tag_i,
  output logic                               lookup_rsp_valid_o,
  output logic                               lookup_hit_o,
  output logic [WAY_COUNT-1:0]               lookup_way_o,
  output logic                               lookup_error_o,
  input  logic                               write_valid_i,
  output logic                               write_ready_o,
  input  logic [COUNT_ALIGN-1:0]             write_addr_i,
  input  logic [$clog2(WAY_COUNT)-1:0]       write_way_i,
  input  logic [TAG_WIDTH-1:0]               write_tag_i,
  input  logic                               write_error_i,
  output logic [WAY_COUNT-1:0]               ram_enable_o,
  output logic                               ram_write_o,
  output logic [COUNT_ALIGN-1:0]             ram_addr_o,
  output logic [TAG_WIDTH+1:0]               ram_wtag_o,
  input  logic [WAY_COUNT*(TAG_WIDTH+2)-1:0] ram_rtag_i
);
  localparam int WordW = TAG_WIDTH + 2;
  localparam logic [COUNT_ALIGN-1:0] LastLine = COUNT_ALIGN'(LINE_COUNT - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_FLUSH} state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [COUNT_ALIGN-1:0] r_cnt;
  logic [COUNT_ALIGN-1:0] w_cnt_next;
  logic                   r_inflight;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic                   w_write_fire;
  logic                   w_lookup_fire;
  logic [WAY_COUNT-1:0]   w_way_onehot;
  logic [WAY_COUNT-1:0]   w_hit;
  logic [WAY_COUNT-1:0]   w_first;
  logic                   w_err;

  // A pending flush blocks both request types so the sweep starts on a quiet bank.
  assign write_ready_o  = (r_state == S_IDLE) && !flush_valid_i;
  assign lookup_ready_o = (r_state == S_IDLE) && !flush_valid_i && !write_valid_i;
  assign w_write_fire   = write_valid_i && write_ready_o;
  assign w_lookup_fire  = lookup_valid_i && lookup_ready_o;
  assign w_way_onehot   = WAY_COUNT'(1) << write_way_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_INIT;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_tag      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_inflight <= w_lookup_fire;
      if (w_lookup_fire) begin
        r_tag <= lookup_tag_i;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    ram_enable_o  = '0;
    ram_write_o   = 1'b0;
    ram_addr_o    = '0;
    ram_wtag_o    = '0;
    flush_ready_o = 1'b0;
    case (r_state)
      S_INIT, S_FLUSH: begin
        ram_enable_o = '1;
        ram_write_o  = 1'b1;
        ram_addr_o   = r_cnt;
        w_cnt_next   = r_cnt + 1'b1;
        if (r_cnt == LastLine) begin
          w_cnt_next    = '0;
          w_state_next  = S_IDLE;
          flush_ready_o = (r_state == S_FLUSH);
        end
      end
      S_IDLE: begin
        if (flush_valid_i) begin
          w_state_next = S_FLUSH;
        end else if (w_write_fire) begin
          ram_enable_o = w_way_onehot;
          ram_write_o  = 1'b1;
          ram_addr_o   = write_addr_i;
          ram_wtag_o   = {1'b1, write_error_i, write_tag_i};
        end else if (w_lookup_fire) begin
          ram_enable_o = '1;
          ram_addr_o   = lookup_addr_i;
        end
      end
      default: begin
        w_state_next = S_INIT;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Lowest-index hit wins when several ways hold the same valid tag.
  always_comb begin
    w_hit = '0;
    w_err = 1'b0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      w_hit[w] = ram_rtag_i[w*WordW + TAG_WIDTH + 1] &&
                 (ram_rtag_i[w*WordW +: TAG_WIDTH] == r_tag);
    end
    w_first = w_hit & (~w_hit + WAY_COUNT'(1));
    for (int w = 0; w < WAY_COUNT; w++) begin
      w_err = w_err | (w_first[w] & ram_rtag_i[w*WordW + TAG_WIDTH]);
    end
  end

  assign lookup_rsp_valid_o = r_inflight;
  assign lookup_hit_o       = r_inflight & (|w_hit);
  assign lookup_way_o       = r_inflight ? w_first : '0;
  assign lookup_error_o     = r_inflight & w_err;

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// tb/tb_snitch_icache_tag_ctrl.sv - self-checking bench for snitch_icache_tag_ctrl
// Includes a behavioural tag SRAM bank and an array-based model of cache contents.
module tb_snitch_icache_tag_ctrl;
  localparam int WAYS  = 4;
  localparam int LINES = 128;
  localparam int TW    = 20;
  localparam int AW    = 7;

  logic clk;
  logic rst_n;
  logic flush_valid, flush_ready;
  logic lookup_valid, lookup_ready;
  logic [AW-1:0] lookup_addr;
  logic [TW-1:0] lookup_tag;
  logic rsp_valid, rsp_hit, rsp_err;
  logic [WAYS-1:0] rsp_way;
  logic write_valid, write_ready;
  logic [AW-1:0] write_addr;
  logic [1:0] write_way;
  logic [TW-1:0] write_tag;
  logic write_error;
  logic [WAYS-1:0] ram_enable;
  logic ram_write;
  logic [AW-1:0] ram_addr;
  logic [TW+1:0] ram_wtag;
  logic [WAYS*(TW+2)-1:0] ram_rtag;

  int n_total = 0;
  int n_pass  = 0;

  snitch_icache_tag_ctrl #(
    .WAY_COUNT(WAYS), .LINE_COUNT(LINES), .TAG_WIDTH(TW), .COUNT_ALIGN(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .flush_valid_i(flush_valid), .flush_ready_o(flush_ready),
    .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
    .lookup_addr_i(lookup_addr), .lookup_tag_i(lookup_tag),
    .lookup_rsp_valid_o(rsp_valid), .lookup_hit_o(rsp_hit),
    .lookup_way_o(rsp_way), .lookup_error_o(rsp_err),
    .write_valid_i(write_valid), .write_ready_o(write_ready),
    .write_addr_i(write_addr), .write_way_i(write_way),
    .write_tag_i(write_tag), .write_error_i(write_error),
    .ram_enable_o(ram_enable), .ram_write_o(ram_write),
    .ram_addr_o(ram_addr), .ram_wtag_o(ram_wtag), .ram_rtag_i(ram_rtag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag SRAM bank: one-cycle read latency, read data held until the next read.
  logic [TW+1:0] sram [WAYS][LINES];
  always @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (ram_enable[w]) begin
        if (ram_write) sram[w][ram_addr] <= ram_wtag;
        else ram_rtag[w*(TW+2) +: (TW+2)] <= sram[w][ram_addr];
      end
    end
  end

  // Reference contents of the cache as seen by the requester.
  bit            mv [WAYS][LINES];
  bit            me [WAYS][LINES];
  logic [TW-1:0] mt [WAYS][LINES];

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++)
      for (int l = 0; l < LINES; l++) begin
        mv[w][l] = 1'b0; me[w][l] = 1'b0; mt[w][l] = '0;
      end
  endtask

  task automatic ref_lookup(input logic [AW-1:0] a, input logic [TW-1:0] t,
                            output bit h, output logic [WAYS-1:0] wy, output bit e);
    h = 1'b0; wy = '0; e = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!h && mv[w][a] && mt[w][a] == t) begin
        h = 1'b1; wy = WAYS'(1 << w); e = me[w][a];
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_reset(input string tag);
    #1;
    chk({tag, "_en"}, 32'(ram_enable), 32'hF);
    chk({tag, "_we"}, 32'(ram_write), 1);
    chk({tag, "_addr"}, 32'(ram_addr), 0);
    chk({tag, "_wtag"}, 32'(ram_wtag), 0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_hit, rsp_way, rsp_err, flush_ready}, 0);
    chk({tag, "_rdy"}, {lookup_ready, write_ready}, 0);
  endtask

  // One IDLE cycle: inputs are already driven; starts and ends at a negedge.
  task automatic cycle();
    bit wf, lf, p_h, p_e;
    logic [WAYS-1:0] p_w;
    p_h = 1'b0; p_e = 1'b0; p_w = '0;
    #1;
    chk("write_ready", 32'(write_ready), 32'(!flush_valid));
    chk("lookup_ready", 32'(lookup_ready), 32'(!flush_valid && !write_valid));
    wf = write_valid && !flush_valid;
    lf = lookup_valid && !flush_valid && !write_valid;
    if (wf) begin
      chk("wr_en", 32'(ram_enable), 32'(1) << write_way);
      chk("wr_we", 32'(ram_write), 1);
      chk("wr_addr", 32'(ram_addr), 32'(write_addr));
      chk("wr_wtag", 32'(ram_wtag), 32'({1'b1, write_error, write_tag}));
    end else if (lf) begin
      chk("rd_en", 32'(ram_enable), 32'hF);
      chk("rd_we", 32'(ram_write), 0);
      chk("rd_addr", 32'(ram_addr), 32'(lookup_addr));
      ref_lookup(lookup_addr, lookup_tag, p_h, p_w, p_e);
    end else begin
      chk("nop_en", 32'(ram_enable), 0);
    end
    @(posedge clk);
    if (wf) begin
      mv[write_way][write_addr] = 1'b1;
      me[write_way][write_addr] = write_error;
      mt[write_way][write_addr] = write_tag;
    end
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(lf));
    chk("rsp_hit", 32'(rsp_hit), 32'(p_h));
    chk("rsp_way", 32'(rsp_way), 32'(p_w));
    chk("rsp_err", 32'(rsp_err), 32'(p_e));
  endtask

  // Sweep cycles starting at sweep address 0; drops flush_valid on the last one.
  task automatic sweep(input bit is_flush, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      #1;
      chk("sw_en", 32'(ram_enable), 32'hF);
      chk("sw_we", 32'(ram_write), 1);
      chk("sw_addr", 32'(ram_addr), 32'(i));
      chk("sw_wtag", 32'(ram_wtag), 0);
      chk("sw_rdy", {lookup_ready, write_ready, rsp_valid}, 0);
      chk("sw_flush_ready", 32'(flush_ready), 32'(is_flush && i == LINES - 1));
      if (i == LINES - 1) flush_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    if (ncyc == LINES) model_clear();
  endtask

  typedef struct {
    bit wv; bit lv;
    logic [AW-1:0] waddr; logic [1:0] wway; logic [TW-1:0] wtag; bit werr;
    logic [AW-1:0] laddr; logic [TW-1:0] ltag;
    bit e_wr; bit e_lk; logic [WAYS-1:0] e_en; bit e_we; logic [AW-1:0] e_addr; logic [TW+1:0] e_wtag;
    bit e_rsp; bit e_hit; logic [WAYS-1:0] e_way; bit e_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0,0, 0,0,0,0, 0,0,                      1,1,4'b0000,0,0,0,            0,0,4'b0000,0};
    vecs[1]  = '{1,0, 5,2,20'hABCDE,0, 0,0,              1,0,4'b0100,1,5,22'h2ABCDE,   0,0,4'b0000,0};
    vecs[2]  = '{0,1, 0,0,0,0, 5,20'hABCDE,              1,1,4'b1111,0,5,0,            1,1,4'b0100,0};
    vecs[3]  = '{0,1, 0,0,0,0, 5,20'h12345,              1,1,4'b1111,0,5,0,            1,0,4'b0000,0};
    vecs[4]  = '{1,0, 9,0,20'h55555,1, 0,0,              1,0,4'b0001,1,9,22'h355555,   0,0,4'b0000,0};
    vecs[5]  = '{1,0, 9,3,20'h55555,0, 0,0,              1,0,4'b1000,1,9,22'h255555,   0,0,4'b0000,0};
    vecs[6]  = '{1,1, 20,1,20'h00777,0, 9,20'h55555,     1,0,4'b0010,1,20,22'h200777,  0,0,4'b0000,0};
    vecs[7]  = '{0,1, 0,0,0,0, 9,20'h55555,              1,1,4'b1111,0,9,0,            1,1,4'b0001,1};
    vecs[8]  = '{0,1, 0,0,0,0, 20,20'h00777,             1,1,4'b1111,0,20,0,           1,1,4'b0010,0};
    vecs[9]  = '{1,0, 20,1,20'h00888,0, 0,0,             1,0,4'b0010,1,20,22'h200888,  0,0,4'b0000,0};
    vecs[10] = '{0,1, 0,0,0,0, 20,20'h00777,             1,1,4'b1111,0,20,0,           1,0,4'b0000,0};
    vecs[11] = '{0,1, 0,0,0,0, 20,20'h00888,             1,1,4'b1111,0,20,0,           1,1,4'b0010,0};

    rst_n = 1'b0;
    flush_valid = 0; lookup_valid = 0; write_valid = 0;
    lookup_addr = '0; lookup_tag = '0; write_addr = '0; write_way = '0;
    write_tag = '0; write_error = 1'b0;
    model_clear();

    repeat (3) @(negedge clk);
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    sweep(1'b0, LINES);
    cycle();

    // Directed vectors; rows without a write or lookup fall through to cycle's own checks.
    for (int i = 0; i < 12; i++) begin
      write_valid = vecs[i].wv; lookup_valid = vecs[i].lv;
      write_addr = vecs[i].waddr; write_way = vecs[i].wway;
      write_tag = vecs[i].wtag; write_error = vecs[i].werr;
      lookup_addr = vecs[i].laddr; lookup_tag = vecs[i].ltag;
      #1;
      chk($sformatf("vec%0d_wr_ready", i), 32'(write_ready), 32'(vecs[i].e_wr));
      chk($sformatf("vec%0d_lk_ready", i), 32'(lookup_ready), 32'(vecs[i].e_lk));
      chk($sformatf("vec%0d_en", i), 32'(ram_enable), 32'(vecs[i].e_en));
      if (vecs[i].e_en != 0) begin
        chk($sformatf("vec%0d_we", i), 32'(ram_write), 32'(vecs[i].e_we));
        chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
      end
      if (vecs[i].e_we) chk($sformatf("vec%0d_wtag", i), 32'(ram_wtag), 32'(vecs[i].e_wtag));
      cycle();
      chk($sformatf("vec%0d_rsp", i), {rsp_valid, rsp_hit, rsp_way, rsp_err},
          {vecs[i].e_rsp, vecs[i].e_hit, vecs[i].e_way, vecs[i].e_err});
    end
    write_valid = 1'b0;

    // Lookup in flight when flush arrives; then flush sweep, then the line must miss.
    lookup_valid = 1'b1; lookup_addr = 5; lookup_tag = 20'hABCDE;
    cycle();
    chk("inflight_hit_at_flush", {rsp_hit, rsp_way}, {1'b1, 4'b0100});
    flush_valid = 1'b1;
    cycle();
    sweep(1'b1, LINES);
    chk("flush_dropped", 32'(flush_valid), 0);
    cycle();
    cycle();
    chk("post_flush_miss", {rsp_valid, rsp_hit, rsp_way}, {1'b1, 1'b0, 4'b0000});
    lookup_valid = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      flush_valid  = ($urandom_range(0, 99) == 0);
      write_valid  = ($urandom_range(0, 2) == 0);
      lookup_valid = $urandom_range(0, 1) == 1;
      write_addr   = AW'($urandom_range(0, 7));
      write_way    = 2'($urandom_range(0, 3));
      write_tag    = 20'hA0000 + TW'($urandom_range(0, 3));
      write_error  = $urandom_range(0, 1) == 1;
      lookup_addr  = AW'($urandom_range(0, 7));
      lookup_tag   = 20'hA0000 + TW'($urandom_range(0, 3));
      if (flush_valid) begin
        cycle();
        sweep(1'b1, LINES);
      end else begin
        cycle();
      end
    end
    flush_valid = 1'b0; write_valid = 1'b0; lookup_valid = 1'b0;

    // Reset while a response is due: it must vanish immediately.
    lookup_valid = 1'b1; lookup_addr = 3; lookup_tag = 20'hA0001;
    @(posedge clk);
    #1;
    chk("rsp_before_reset", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    lookup_valid = 1'b0;
    chk_reset("mid_lookup_reset");
    @(negedge clk);
    rst_n = 1'b1;
    sweep(1'b0, LINES);

    // Reset at flush sweep cycle 40: sweep restarts from address 0 as INIT.
    flush_valid = 1'b1;
    cycle();
    sweep(1'b1, 40);
    rst_n = 1'b0;
    flush_valid = 1'b0;
    chk_reset("mid_sweep_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    sweep(1'b0, LINES);
    lookup_valid = 1'b1; lookup_addr = 5; lookup_tag = 20'hABCDE;
    cycle();
    lookup_valid = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/snitch_icache_tag_ctrl.md
Name: snitch_icache_tag_ctrl

Overview:
- Initiator side of the instruction-cache tag memory.
- Owns every request to the per-way tag SRAMs: enable, write, address and write tag.
- Consumes the 1-cycle-latency read tags and produces hit/way/error lookup responses.
- Performs the post-reset invalidation sweep, refill tag writes and full-cache flush.
- Sits between the lookup stage / refill handler and the tag SRAM bank.

Parameters:
- WAY_COUNT, 4: number of ways (tag SRAM instances).
- LINE_COUNT, 128: lines per way.
- TAG_WIDTH, 20: address tag width.
- COUNT_ALIGN, $clog2(LINE_COUNT): line-index width (derived).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- flush_valid_i  in  1  flush request; held until handshake completes
- flush_ready_o  out  1  1-cycle pulse when the flush sweep is done
- lookup_valid_i  in  1  lookup request
- lookup_ready_o  out  1  lookup accepted
- lookup_addr_i  in  COUNT_ALIGN  line index
- lookup_tag_i  in  TAG_WIDTH  tag to compare
- lookup_rsp_valid_o  out  1  response pulse; no backpressure
- lookup_hit_o  out  1  valid tag match in some way
- lookup_way_o  out  WAY_COUNT  one-hot hit way (lowest index)
- lookup_error_o  out  1  error bit of the hit way
- write_valid_i  in  1  refill tag write request
- write_ready_o  out  1  write accepted
- write_addr_i  in  COUNT_ALIGN  line index
- write_way_i  in  $clog2(WAY_COUNT)  target way
- write_tag_i  in  TAG_WIDTH  tag
- write_error_i  in  1  refill error flag
- ram_enable_o  out  WAY_COUNT  per-way SRAM request
- ram_write_o  out  1  SRAM write enable
- ram_addr_o  out  COUNT_ALIGN  SRAM address
- ram_wtag_o  out  TAG_WIDTH+2  write word {valid, error, tag}
- ram_rtag_i  in  WAY_COUNT x (TAG_WIDTH+2)  read words, valid 1 cycle after a read request

Behaviour:
- Tag word format: bit TAG_WIDTH+1 = valid, bit TAG_WIDTH = error, [TAG_WIDTH-1:0] = tag.
- FSM states INIT, IDLE, FLUSH, plus a COUNT_ALIGN-bit sweep counter. Reset enters INIT with counter 0.
- INIT and FLUSH: each cycle drive ram_enable_o='1, ram_write_o=1, ram_addr_o=counter, ram_wtag_o=0, then increment the counter.
  - When the write at LINE_COUNT-1 issues, clear the counter and go to IDLE.
  - FLUSH additionally asserts flush_ready_o in that last cycle.
  - The sweep takes exactly LINE_COUNT cycles.
- lookup_ready_o and write_ready_o are 0 in INIT and FLUSH.
- Values while rst_ni is low:
  - ram_enable_o='1, ram_write_o=1, ram_addr_o=0, ram_wtag_o=0.
  - lookup_rsp_valid_o, lookup_hit_o, lookup_way_o, lookup_error_o, flush_ready_o all 0.
  - lookup_ready_o and write_ready_o are 0.
- IDLE priority: flush > write > lookup.
  - flush_valid_i seen in IDLE: enter FLUSH next cycle. No request is accepted in that cycle.
  - Write: write_ready_o=1 when no flush is pending.
    - On fire, drive ram_enable_o=onehot(write_way_i), ram_write_o=1, ram_addr_o=write_addr_i, ram_wtag_o={1, write_error_i, write_tag_i}.
  - Lookup: lookup_ready_o=1 when no flush and no write_valid_i.
    - On fire, drive ram_enable_o='1, ram_write_o=0, ram_addr_o=lookup_addr_i.
    - Register lookup_tag_i and an in-flight flag.
  - No request: ram_enable_o=0.
- Response timing: one cycle after a lookup fire, lookup_rsp_valid_o=1 for exactly one cycle.
  - Hit vector: per way, valid AND tag equal to the registered tag.
  - lookup_way_o: lowest set bit of the hit vector (one-hot, or 0 when there is no hit).
  - lookup_hit_o: OR of the hit vector.
  - lookup_error_o: error bit of the selected way (0 on miss).
  - Response outputs are 0 when lookup_rsp_valid_o=0.
- Throughput: back-to-back lookups give 1 response per cycle.
- Same-line write following a lookup: the response reflects SRAM contents before the write.
- A lookup in flight when a flush begins still returns its response, computed from pre-flush contents.
- Asynchronous reset mid-sweep or mid-lookup: the in-flight response is dropped and the sweep restarts from 0.

Test Plan:
- Reset release -> ram_write_o=1 with addresses 0..127 on consecutive cycles, wtag 0. lookup_ready_o rises on cycle 128.
- Write way 2, line 5, tag 0xABCDE, error 0; then lookup line 5, tag 0xABCDE -> ram_enable_o=4'b0100 on the write. Next-cycle response: hit=1, way=4'b0100, error=0.
- Lookup line 5, tag 0x12345 -> response valid, hit=0, way=0.
- Write ways 0 and 3 at line 9 with equal tag, ways 0 and 3 carrying error 1 and 0 respectively; lookup line 9 -> hit=1, way=4'b0001, error=1.
- write_valid_i and lookup_valid_i in the same cycle -> write_ready_o=1, lookup_ready_o=0; the lookup fires the next cycle.
- Populated cache, flush_valid_i held -> flush_ready_o pulses 129 cycles later: 1 transition cycle plus 128 sweep cycles. A later lookup of line 5 misses. Apply reset at sweep cycle 40 -> the sweep restarts at address 0.
